// File: rtl/clk_set_ctrl.sv
// Key-driven RUN/SET sequencer for the clock digit datapath, with a cursor blink mask.
// Optional build macro SET_TIMEOUT_EN adds auto-exit from SET after key inactivity.
module clk_set_ctrl #(
    parameter logic [25:0] CNT_BLINK_MAX = 26'd24_999_999
`ifdef SET_TIMEOUT_EN
    ,
    parameter logic [25:0] CNT_1S_MAX    = 26'd49_999_999,
    parameter logic [4:0]  TIMEOUT_S     = 5'd10
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_shift,
    input  logic       key_inc,
    output logic       work_en,
    output logic [2:0] set_pos,
    output logic [3:0] set_data,
    output logic       set_flag,
    output logic [5:0] blink_mask
);

    typedef enum logic [2:0] {RUN, SET, FIX, COMMIT1, COMMIT2} ctrlState_t;

    ctrlState_t       r_state, w_nextState;
    logic [2:0]       r_cursor, w_nextCursor;
    logic [5:0][3:0]  r_digits, w_nextDigits;
    logic             r_workEn, w_nextWorkEn;
    logic [2:0]       r_setPos, w_nextPos;
    logic [3:0]       r_setData, w_nextData;
    logic             r_setFlag, w_nextFlag;
    logic [5:0]       r_blinkMask, w_nextMask;
    logic [25:0]      r_blinkCnt, w_nextBlinkCnt;
    logic             r_blinkOff, w_nextBlinkOff;

    logic             w_anyKey;
    logic             w_timeout;
    logic [3:0]       w_curDigit;
    logic [3:0]       w_limit;
    logic [3:0]       w_incVal;

    assign w_anyKey   = key_mode | key_shift | key_inc;
    assign w_curDigit = r_digits[r_cursor];
    assign w_incVal   = (w_curDigit >= w_limit) ? 4'd0 : w_curDigit + 4'd1;

    // Hour-low may only reach 3 once hour-high is 2 (24-hour clock)
    always_comb begin
        w_limit = 4'd9;
        case (r_cursor)
            3'd1, 3'd3: w_limit = 4'd5;
            3'd4:       w_limit = (r_digits[5] == 4'd2) ? 4'd3 : 4'd9;
            3'd5:       w_limit = 4'd2;
            default:    w_limit = 4'd9;
        endcase
    end

`ifdef SET_TIMEOUT_EN
    logic [25:0] r_tickCnt;
    logic [4:0]  r_idleSec;

    // Fires on the tick that would bring the idle count up to TIMEOUT_S
    assign w_timeout = (r_state == SET) && !w_anyKey && (r_tickCnt == CNT_1S_MAX)
                       && (r_idleSec == TIMEOUT_S - 5'd1);

    always_ff @(posedge clk) begin
        if (!rst_n || r_state != SET || w_anyKey) begin
            r_tickCnt <= '0;
            r_idleSec <= '0;
        end else if (r_tickCnt == CNT_1S_MAX) begin
            r_tickCnt <= '0;
            r_idleSec <= r_idleSec + 5'd1;
        end else begin
            r_tickCnt <= r_tickCnt + 26'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Outputs are computed for the next state so they register alongside it
    always_comb begin
        w_nextState  = r_state;
        w_nextCursor = r_cursor;
        w_nextDigits = r_digits;
        w_nextWorkEn = r_workEn;
        w_nextPos    = r_setPos;
        w_nextData   = r_setData;
        w_nextFlag   = 1'b0;
        case (r_state)
            RUN: begin
                w_nextWorkEn = 1'b1;
                if (key_mode) begin
                    w_nextState  = SET;
                    w_nextWorkEn = 1'b0;
                    w_nextCursor = 3'd0;
                    w_nextPos    = 3'd0;
                    w_nextData   = 4'd0;
                    w_nextDigits = '0;
                end
            end
            SET: begin
                w_nextPos  = r_cursor;
                w_nextData = w_curDigit;
                if (key_mode || w_timeout) begin
                    w_nextState = COMMIT1;
                    w_nextFlag  = 1'b1;
                end else if (key_shift) begin
                    w_nextCursor = (r_cursor == 3'd5) ? 3'd0 : r_cursor + 3'd1;
                    w_nextPos    = w_nextCursor;
                    w_nextData   = r_digits[w_nextCursor];
                end else if (key_inc) begin
                    w_nextDigits[r_cursor] = w_incVal;
                    w_nextData             = w_incVal;
                    w_nextFlag             = 1'b1;
                    if (r_cursor == 3'd5 && w_incVal == 4'd2 && r_digits[4] > 4'd3)
                        w_nextState = FIX;
                end
            end
            FIX: begin
                w_nextState     = SET;
                w_nextDigits[4] = 4'd0;
                w_nextPos       = 3'd4;
                w_nextData      = 4'd0;
                w_nextFlag      = 1'b1;
            end
            COMMIT1: begin
                w_nextState  = COMMIT2;
                w_nextWorkEn = 1'b0;
            end
            COMMIT2: begin
                w_nextState  = RUN;
                w_nextWorkEn = 1'b1;
            end
            default: w_nextState = RUN;
        endcase

        if (r_state == RUN || w_anyKey) begin
            w_nextBlinkCnt = '0;
            w_nextBlinkOff = 1'b0;
        end else if (r_blinkCnt == CNT_BLINK_MAX) begin
            w_nextBlinkCnt = '0;
            w_nextBlinkOff = ~r_blinkOff;
        end else begin
            w_nextBlinkCnt = r_blinkCnt + 26'd1;
            w_nextBlinkOff = r_blinkOff;
        end

        if (w_nextState == RUN)
            w_nextMask = 6'b111111;
        else
            w_nextMask = ~(6'(w_nextBlinkOff) << w_nextPos);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_cursor    <= '0;
            r_digits    <= '0;
            r_workEn    <= 1'b1;
            r_setPos    <= '0;
            r_setData   <= '0;
            r_setFlag   <= 1'b0;
            r_blinkMask <= 6'b111111;
            r_blinkCnt  <= '0;
            r_blinkOff  <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_cursor    <= w_nextCursor;
            r_digits    <= w_nextDigits;
            r_workEn    <= w_nextWorkEn;
            r_setPos    <= w_nextPos;
            r_setData   <= w_nextData;
            r_setFlag   <= w_nextFlag;
            r_blinkMask <= w_nextMask;
            r_blinkCnt  <= w_nextBlinkCnt;
            r_blinkOff  <= w_nextBlinkOff;
        end
    end

    assign work_en    = r_workEn;
    assign set_pos    = r_setPos;
    assign set_data   = r_setData;
    assign set_flag   = r_setFlag;
    assign blink_mask = r_blinkMask;

endmodule

// File: tb/tb_clk_set_ctrl.sv
// Directed bench for clk_set_ctrl: key sequences with hand-computed strobes and blink masks.
// Build with SET_TIMEOUT_EN defined to also exercise the inactivity auto-exit.
module tb_clk_set_ctrl;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       keyMode = 1'b0;
    logic       keyShift = 1'b0;
    logic       keyInc = 1'b0;
    logic       workEn;
    logic [2:0] setPos;
    logic [3:0] setData;
    logic       setFlag;
    logic [5:0] blinkMask;

    int checkCount = 0;
    int passCount  = 0;

    clk_set_ctrl #(
        .CNT_BLINK_MAX(26'd3)
`ifdef SET_TIMEOUT_EN
        ,
        .CNT_1S_MAX(26'd9),
        .TIMEOUT_S(5'd2)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rstN),
        .key_mode(keyMode),
        .key_shift(keyShift),
        .key_inc(keyInc),
        .work_en(workEn),
        .set_pos(setPos),
        .set_data(setData),
        .set_flag(setFlag),
        .blink_mask(blinkMask)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic m, input logic s, input logic i);
        keyMode  = m;
        keyShift = s;
        keyInc   = i;
        step();
        keyMode  = 1'b0;
        keyShift = 1'b0;
        keyInc   = 1'b0;
    endtask

    task automatic checkStrobe(input string tag, input int pos, input int data);
        checkOutput({tag, ".flag"}, 32'(setFlag), 1);
        checkOutput({tag, ".pos"},  32'(setPos),  pos);
        checkOutput({tag, ".data"}, 32'(setData), data);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b0;
        repeat (3) step();
        rstN = 1'b1;
        repeat (100) step();
        checkOutput("idle.work_en", 32'(workEn), 1);
        checkOutput("idle.flag", 32'(setFlag), 0);
        checkOutput("idle.mask", 32'(blinkMask), 32'h3F);
        checkOutput("idle.pos", 32'(setPos), 0);

        // enter SET, three increments at seconds-low, then commit
        applyStimulus(1, 0, 0);
        checkOutput("enter.work_en", 32'(workEn), 0);
        checkOutput("enter.flag", 32'(setFlag), 0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 0, 1);
            checkStrobe($sformatf("inc0_%0d", k), 0, k);
        end
        step();
        checkOutput("inc0.idle_flag", 32'(setFlag), 0);
        applyStimulus(1, 0, 0);
        checkStrobe("commit1", 0, 3);
        checkOutput("commit1.work_en", 32'(workEn), 0);
        step();
        checkOutput("commit2.flag", 32'(setFlag), 0);
        checkOutput("commit2.work_en", 32'(workEn), 0);
        step();
        checkOutput("run.work_en", 32'(workEn), 1);

        // cursor walk and hour-high wrap
        applyStimulus(1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(0, 1, 0);
            checkOutput($sformatf("shift_%0d.pos", k), 32'(setPos), k);
            checkOutput($sformatf("shift_%0d.flag", k), 32'(setFlag), 0);
        end
        applyStimulus(0, 0, 1);
        checkStrobe("hh_1", 5, 1);
        applyStimulus(0, 0, 1);
        checkStrobe("hh_2", 5, 2);
        applyStimulus(0, 0, 1);
        checkStrobe("hh_wrap", 5, 0);
        applyStimulus(0, 1, 0);
        checkOutput("shift_wrap.pos", 32'(setPos), 0);
        for (int k = 0; k < 6; k++) applyStimulus(0, 1, 0);
        checkOutput("shift_six.pos", 32'(setPos), 0);

        // hour-low 7 then hour-high 2 forces the FIX write of hour-low 0
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0);
        for (int k = 0; k < 7; k++) applyStimulus(0, 0, 1);
        checkStrobe("hl_7", 4, 7);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 1);
        checkStrobe("fix_hh1", 5, 1);
        applyStimulus(0, 0, 1);
        checkStrobe("fix_hh2", 5, 2);
        step();
        checkStrobe("fix_hl0", 4, 0);
        step();
        checkOutput("fix_ret.pos", 32'(setPos), 5);
        checkOutput("fix_ret.flag", 32'(setFlag), 0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 1, 0);
        checkOutput("to_hl.pos", 32'(setPos), 4);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 1);
            checkStrobe($sformatf("hl_lim3_%0d", k), 4, k % 4);
        end

        // blink phase on cursor 4, counter restarted by the last increment
        for (int k = 1; k <= 8; k++) begin
            step();
            checkOutput($sformatf("blink_%0d", k), 32'(blinkMask),
                        ((k / 4) % 2 == 1) ? 32'h2F : 32'h3F);
        end

        // mode wins over inc in the same cycle
        applyStimulus(1, 0, 1);
        checkStrobe("mode_inc", 4, 0);
        step();
        checkOutput("mode_inc.c2_work_en", 32'(workEn), 0);
        step();
        checkOutput("mode_inc.run_work_en", 32'(workEn), 1);
        checkOutput("mode_inc.run_mask", 32'(blinkMask), 32'h3F);

        // shift and inc ignored in RUN
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 1);
        checkOutput("run_keys.pos", 32'(setPos), 4);
        checkOutput("run_keys.flag", 32'(setFlag), 0);
        checkOutput("run_keys.work_en", 32'(workEn), 1);

        // reset in the middle of a set abandons it with no strobe
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 1);
        checkStrobe("pre_rst", 0, 1);
        rstN   = 1'b0;
        keyInc = 1'b1;
        step();
        keyInc = 1'b0;
        checkOutput("rst.work_en", 32'(workEn), 1);
        checkOutput("rst.flag", 32'(setFlag), 0);
        checkOutput("rst.pos", 32'(setPos), 0);
        checkOutput("rst.mask", 32'(blinkMask), 32'h3F);
        rstN = 1'b1;
        step();

`ifdef SET_TIMEOUT_EN
        begin
            int cycles = 0;
            applyStimulus(1, 0, 0);
            while (!setFlag && cycles < 100) begin
                step();
                cycles++;
            end
            checkOutput("timeout.cycles", 32'(cycles), 20);
            checkStrobe("timeout", 0, 0);
            step();
            step();
            checkOutput("timeout.work_en", 32'(workEn), 1);
        end
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
